// File: rtl/xls_collector_pkg.sv
// Shared constants and helpers for the XLS pipeline result collector.
//
// Contents:
//   COLLECTOR_DEFAULT_DEPTH    default result FIFO depth (= total issue credits)
//   COLLECTOR_DEFAULT_LATENCY  default pipeline latency in cycles
//   clog2_plus1(n)             bits needed to hold the values 0..n
package xls_collector_pkg;

    localparam int COLLECTOR_DEFAULT_DEPTH   = 4;
    localparam int COLLECTOR_DEFAULT_LATENCY = 2;

    function automatic int clog2_plus1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xls_collector_fifo.sv
// In-order result FIFO with a first-word-fall-through head read from a
// registered array. Storage, wrap-around pointers and overflow drop live here.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset (empties the FIFO)
//   push        write request; dropped when full unless a pop happens too
//   push_data   write payload
//   pop         consume the head entry; ignored while empty
//   head_valid  FIFO not empty
//   head_data   oldest entry
//   full        DEPTH entries held
//   empty       no entries held
module xls_collector_fifo
    import xls_collector_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = COLLECTOR_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = clog2_plus1(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr];

    // A push while full is accepted only if the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/xls_pipe_result_collector.sv
// Issue/return end of a fixed-latency, valid-only generated pipeline.
// Upstream ready/valid requests are issued into the pipeline only while a
// credit is available; every credit reserves one result FIFO slot, so results
// are never lost while the downstream consumer stalls.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset (also resets the pipeline)
//   req_valid/ready upstream request handshake; req_data is the payload
//   pipe_in_valid   pipeline input_valid (= accepted request)
//   pipe_in_data    pipeline data input (req_data passed straight through)
//   pipe_out_valid  pipeline output_valid; pipe_out_data is its payload
//   rsp_valid/ready downstream result handshake; rsp_data is the FIFO head
//   overflow_err    sticky: a result arrived while the FIFO was full
//
// Build option: define XLS_COLLECTOR_CHECK_EN to add an in-flight tracker and
// protocol assertions (the assertions also need ASSERT_ON).
module xls_pipe_result_collector
    import xls_collector_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = COLLECTOR_DEFAULT_LATENCY,
    parameter int DEPTH   = COLLECTOR_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             pipe_in_valid,
    output logic [WIDTH-1:0] pipe_in_data,
    input  logic             pipe_out_valid,
    input  logic [WIDTH-1:0] pipe_out_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             overflow_err
);

    localparam int CNT_W = clog2_plus1(DEPTH);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH);

    if (LATENCY < 1 || DEPTH < 1) begin : g_bad_params
        $error("xls_pipe_result_collector: LATENCY and DEPTH must both be >= 1");
    end

    logic [CNT_W-1:0] credit_cnt;
    logic             issue;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    assign req_ready     = !rst && (credit_cnt != '0);
    assign issue         = req_valid && req_ready;
    assign pipe_in_valid = issue;
    assign pipe_in_data  = req_data;

    assign pop  = rsp_valid && rsp_ready;
    // Returns seen during reset belong to discarded work.
    assign push = pipe_out_valid && !rst;

    xls_collector_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (pipe_out_data),
        .pop        (pop),
        .head_valid (rsp_valid),
        .head_data  (rsp_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Increment saturates at DEPTH: exceeding it is only possible after a
    // spurious pipeline return, and wrapping would then block all issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CREDIT_MAX;
        end else begin
            case ({issue, pop})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   credit_cnt <= (credit_cnt == CREDIT_MAX) ? credit_cnt
                                                                  : credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_err <= 1'b1;
        end
    end

`ifdef XLS_COLLECTOR_CHECK_EN
    localparam int FLT_W = clog2_plus1(LATENCY);

    logic [FLT_W-1:0] in_flight;
    logic [CNT_W-1:0] occupancy;
    logic             ret;
    logic             fifo_write;

    // Saturate at zero so a spurious return is flagged without corrupting the count.
    assign ret        = pipe_out_valid && (in_flight != '0);
    assign fifo_write = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            case ({fifo_write, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef ASSERT_ON
`ifndef BR_ASSERT
`define BR_ASSERT(name, expr) name : assert property (@(posedge clk) disable iff (rst) (expr));
`endif
    `BR_ASSERT(no_overflow, !(push && fifo_full && !pop))
    `BR_ASSERT(credit_conserve, (int'(occupancy) + int'(in_flight) + int'(credit_cnt)) == DEPTH)
    `BR_ASSERT(in_flight_bound, int'(in_flight) <= LATENCY)
    `BR_ASSERT(no_spurious_return, !pipe_out_valid || (in_flight != '0))
`endif
`endif

endmodule

// File: tb/tb_xls_pipe_result_collector.sv
// Directed bench for xls_pipe_result_collector (WIDTH=1, LATENCY=2, DEPTH=4)
// with a behavioural two-stage delay line standing in for the pipeline.
module tb_xls_pipe_result_collector;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_data;
    logic pipe_in_valid, pipe_in_data;
    logic pipe_out_valid, pipe_out_data;
    logic rsp_valid, rsp_ready, rsp_data;
    logic overflow_err;

    logic v1, v2, d1, d2;
    logic force_ov, force_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xls_pipe_result_collector #(.WIDTH(1), .LATENCY(2), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_in_data   (pipe_in_data),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_data  (pipe_out_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .overflow_err   (overflow_err)
    );

    // Pipeline model: latency 2, reset by the same rst.
    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= pipe_in_valid;
            v2 <= v1;
        end
        d1 <= pipe_in_data;
        d2 <= d1;
    end

    assign pipe_out_valid = force_ov | v2;
    assign pipe_out_data  = force_ov ? force_data : d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timed out");
    end

    logic s_d  [8];
    logic bp_d [4];
    logic ov_d [5];
    int   got, first_c, issues;
    logic ready_drop, seen;

    initial begin
        s_d  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_d = '{1'b0, 1'b1, 1'b1, 1'b0};
        ov_d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset held 3 cycles with a pending request.
        rst = 1'b1; req_valid = 1'b1; req_data = 1'b0; rsp_ready = 1'b0;
        force_ov = 1'b0; force_data = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_pipe_in_valid", 32'(pipe_in_valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_overflow_err", 32'(overflow_err), 0);
        chk("rst_credit_cnt", 32'(dut.credit_cnt), 4);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("rel_req_ready", 32'(req_ready), 1);

        // Streaming: 8 back-to-back requests, consumer always ready.
        rsp_ready = 1'b1; got = 0; first_c = -1; ready_drop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 8);
            req_data  = (c < 8) ? s_d[c] : 1'b0;
            #1;
            if (c < 8 && !req_ready) ready_drop = 1'b1;
            if (rsp_valid) begin
                if (first_c < 0) first_c = c;
                if (got < 8) chk("stream_data", 32'(rsp_data), 32'(s_d[got]));
                got++;
            end
            tick();
        end
        chk("stream_first_latency", first_c, 3);
        chk("stream_count", got, 8);
        chk("stream_ready_drop", 32'(ready_drop), 0);
        chk("stream_credits", 32'(dut.credit_cnt), 4);

        // Backpressure: consumer stalled, credits limit issue to 4.
        rsp_ready = 1'b0; issues = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_data  = (issues < 4) ? bp_d[issues] : 1'b0;
            #1;
            if (req_ready) issues++;
            tick();
        end
        chk("bp_issues", issues, 4);
        chk("bp_req_ready", 32'(req_ready), 0);
        chk("bp_fifo_full", 32'(dut.u_fifo.full), 1);
        chk("bp_overflow_err", 32'(overflow_err), 0);
        chk("bp_credits_used", 32'(dut.credit_cnt), 0);
        req_valid = 1'b0; rsp_ready = 1'b1; got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid) begin
                if (got < 4) chk("bp_data", 32'(rsp_data), 32'(bp_d[got]));
                got++;
            end
            tick();
        end
        chk("bp_drain_count", got, 4);
        chk("bp_credits_back", 32'(dut.credit_cnt), 4);

        // Simultaneous issue and pop at credit_cnt == 1.
        rsp_ready = 1'b0; req_valid = 1'b1; req_data = 1'b1;
        repeat (3) tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("sim_pre_credits", 32'(dut.credit_cnt), 1);
        req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("sim_rsp_valid", 32'(rsp_valid), 1);
        chk("sim_req_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("sim_post_credits", 32'(dut.credit_cnt), 1);
        chk("sim_post_req_ready", 32'(req_ready), 1);
        repeat (8) tick();
        chk("sim_drain_credits", 32'(dut.credit_cnt), 4);
        chk("sim_drain_empty", 32'(rsp_valid), 0);

        // Mid-operation reset: 2 buffered, one returning now, one more in the pipe.
        rsp_ready = 1'b0; req_valid = 1'b1; req_data = 1'b1;
        repeat (4) tick();
        req_valid = 1'b0;
        #1;
        chk("mid_buffered", 32'(dut.u_fifo.count), 2);
        chk("mid_returning", 32'(pipe_out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_credits", 32'(dut.credit_cnt), 4);
        chk("mid_req_ready", 32'(req_ready), 1);
        rsp_ready = 1'b1; seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        chk("mid_no_stale_result", 32'(seen), 0);

        // Injected overflow: 5 spurious returns into a stalled 4-entry FIFO.
        rsp_ready = 1'b0; req_valid = 1'b0; force_ov = 1'b1;
        for (int k = 0; k < 5; k++) begin
            force_data = ov_d[k];
            #1;
            chk("ovf_before_5th", 32'(overflow_err), 0);
            tick();
        end
        force_ov = 1'b0;
        chk("ovf_set", 32'(overflow_err), 1);
        chk("ovf_fifo_full", 32'(dut.u_fifo.full), 1);
        chk("ovf_credits", 32'(dut.credit_cnt), 4);
        rsp_ready = 1'b1; got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rsp_valid) begin
                if (got < 4) chk("ovf_data", 32'(rsp_data), 32'(ov_d[got]));
                got++;
            end
            tick();
        end
        chk("ovf_stored_count", got, 4);
        chk("ovf_sticky", 32'(overflow_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ovf_cleared_by_rst", 32'(overflow_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
